// File: rtl/tamagotchi_cmd_sched_if.sv
// tamagotchi_cmd_sched_if: valid/ready stat-command channel from scheduler to stat datapath
interface tamagotchi_cmd_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_sel;
  logic [1:0] cmd_op;
  modport master (output cmd_valid, cmd_sel, cmd_op, input cmd_ready);
  modport slave (input cmd_valid, cmd_sel, cmd_op, output cmd_ready);
endinterface

// File: rtl/tamagotchi_cmd_sched.sv
// tamagotchi_cmd_sched: serializes button presses and decay ticks into stat-update commands
module tamagotchi_cmd_sched #(
  parameter int DECAY_SALUD     = 120,
  parameter int DECAY_ENERGIA   = 100,
  parameter int DECAY_HAMBRE    = 70,
  parameter int DECAY_DIVERSION = 50,
  parameter int TEST_HOLD       = 5
) (
  input  logic                   clk,
  input  logic                   btn_reset,
  input  logic                   tick_1s,
  input  logic                   btn_salud,
  input  logic                   btn_energia,
  input  logic                   btn_hambre,
  input  logic                   btn_diversion,
  input  logic                   btn_test,
  tamagotchi_cmd_sched_if.master cmd,
  output logic [1:0]             view_sel,
  output logic                   test_mode
);
  localparam logic [1:0] OP_INC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;
  localparam logic [1:0] OP_MIN = 2'd2;
  localparam logic [1:0] OP_MAX = 2'd3;
  localparam logic [7:0] LAST [4] = '{8'(DECAY_SALUD - 1), 8'(DECAY_ENERGIA - 1),
                                     8'(DECAY_HAMBRE - 1), 8'(DECAY_DIVERSION - 1)};
  localparam logic [7:0] HOLD_LAST = 8'(TEST_HOLD - 1);
  localparam logic [7:0] HOLD_MAX = 8'(TEST_HOLD);
  function automatic logic [1:0] first(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  logic [3:0] btn, btn_q, edg, usr_pend, dec_pend, force_tgl, usr_set, expire;
  logic [3:0] usr_av, dec_av, clr, usr_clr, dec_clr;
  logic [7:0] cnt [4];
  logic [7:0] hold;
  logic       fired, mode_chg, arb, use_usr, load;
  logic [1:0] press, pick, op_nxt;
  // edge detect, decay expiry, test toggle and arbitration decisions for this cycle
  always_comb begin
    btn = {btn_diversion, btn_hambre, btn_energia, btn_salud};
    edg = btn & ~btn_q;
    press = first(edg);
    usr_set = (|edg && press == view_sel) ? 4'b0001 << press : 4'b0000;
    for (int i = 0; i < 4; i++) expire[i] = tick_1s && !test_mode && cnt[i] == LAST[i];
    mode_chg = tick_1s && btn_test && !fired && hold == HOLD_LAST;
    usr_av = mode_chg ? 4'b0000 : usr_pend;
    dec_av = mode_chg ? 4'b0000 : dec_pend;
    use_usr = |usr_av;
    pick = use_usr ? first(usr_av) : first(dec_av);
    arb = !cmd.cmd_valid || cmd.cmd_ready;
    load = arb && (use_usr || |dec_av);
    clr = load ? 4'b0001 << pick : 4'b0000;
    usr_clr = use_usr ? clr : 4'b0000;
    dec_clr = use_usr ? 4'b0000 : clr;
    op_nxt = !use_usr ? OP_DEC : !test_mode ? OP_INC : force_tgl[pick] ? OP_MAX : OP_MIN;
  end
  // button history tracks levels even in reset so buttons held across reset are not presses
  always_ff @(posedge clk) btn_q <= btn;
  // view selection, test-mode latch, pending sets, decay counters and command register
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      view_sel <= '0;
      test_mode <= 1'b0;
      hold <= '0;
      fired <= 1'b0;
      usr_pend <= '0;
      dec_pend <= '0;
      force_tgl <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_sel <= '0;
      cmd.cmd_op <= '0;
    end else begin
      if (|edg && press != view_sel) view_sel <= press;
      if (!btn_test) begin
        hold <= '0;
        fired <= 1'b0;
      end else if (tick_1s && hold != HOLD_MAX) hold <= hold + 8'd1;
      if (mode_chg) begin
        test_mode <= !test_mode;
        fired <= 1'b1;
        usr_pend <= '0;
        dec_pend <= '0;
        force_tgl <= '0;
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
        usr_pend <= (usr_pend & ~usr_clr) | usr_set;
        dec_pend <= (dec_pend & ~dec_clr) | expire;
        force_tgl <= force_tgl ^ (test_mode ? usr_clr : 4'b0000);
        if (tick_1s && !test_mode)
          for (int i = 0; i < 4; i++) cnt[i] <= expire[i] ? 8'd0 : cnt[i] + 8'd1;
      end
      if (arb) cmd.cmd_valid <= load;
      if (load) begin
        cmd.cmd_sel <= pick;
        cmd.cmd_op <= op_nxt;
      end
    end
  end
endmodule

// File: tb/tb_tamagotchi_cmd_sched.sv
// tb_tamagotchi_cmd_sched: directed checks of presses, decay, arbitration and test mode
module tb_tamagotchi_cmd_sched;
  logic clk = 1'b0;
  logic btn_reset = 1'b1, tick_1s = 1'b0, btn_test = 1'b0;
  logic btn_salud = 1'b0, btn_energia = 1'b0, btn_hambre = 1'b0, btn_diversion = 1'b0;
  logic [1:0] view_sel;
  logic test_mode;
  int n_run = 0, n_fail = 0;
  logic seen;
  tamagotchi_cmd_sched_if cmd_if ();
  tamagotchi_cmd_sched #(
    .DECAY_SALUD(200), .DECAY_ENERGIA(6), .DECAY_HAMBRE(6), .DECAY_DIVERSION(3), .TEST_HOLD(5)
  ) dut (
    .clk(clk), .btn_reset(btn_reset), .tick_1s(tick_1s),
    .btn_salud(btn_salud), .btn_energia(btn_energia), .btn_hambre(btn_hambre),
    .btn_diversion(btn_diversion), .btn_test(btn_test),
    .cmd(cmd_if), .view_sel(view_sel), .test_mode(test_mode)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input int gap);
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
    repeat (gap) cyc();
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_cmd(input string tag, input logic v, input logic [1:0] s, input logic [1:0] o);
    chk({tag, ".valid"}, {7'd0, cmd_if.cmd_valid}, {7'd0, v});
    if (v) begin
      chk({tag, ".sel"}, {6'd0, cmd_if.cmd_sel}, {6'd0, s});
      chk({tag, ".op"}, {6'd0, cmd_if.cmd_op}, {6'd0, o});
    end
  endtask
  initial begin
    cmd_if.cmd_ready = 1'b0;
    {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_test} = 5'b11111;
    cyc();
    cyc();
    chk_cmd("rst", 1'b0, 2'd0, 2'd0);
    chk("rst.sel", {6'd0, cmd_if.cmd_sel}, 8'd0);
    chk("rst.op", {6'd0, cmd_if.cmd_op}, 8'd0);
    chk("rst.view", {6'd0, view_sel}, 8'd0);
    chk("rst.test", {7'd0, test_mode}, 8'd0);
    btn_reset = 1'b0;
    repeat (3) cyc();
    chk_cmd("held_after_rst", 1'b0, 2'd0, 2'd0);
    chk("held_after_rst.view", {6'd0, view_sel}, 8'd0);
    {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_test} = 5'b00000;
    cyc();
    cmd_if.cmd_ready = 1'b1;
    btn_hambre = 1'b1;
    cyc();
    chk("view_hambre", {6'd0, view_sel}, 8'd2);
    chk_cmd("view_nocmd", 1'b0, 2'd0, 2'd0);
    btn_hambre = 1'b0;
    cyc();
    chk_cmd("view_nocmd2", 1'b0, 2'd0, 2'd0);
    btn_hambre = 1'b1;
    cyc();
    chk_cmd("inc_lat0", 1'b0, 2'd0, 2'd0);
    cyc();
    chk_cmd("inc_hambre", 1'b1, 2'd2, 2'd0);
    cyc();
    chk_cmd("inc_once", 1'b0, 2'd0, 2'd0);
    btn_hambre = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    tick(9);
    chk_cmd("decay_t1", 1'b0, 2'd0, 2'd0);
    tick(9);
    chk_cmd("decay_t2", 1'b0, 2'd0, 2'd0);
    tick(0);
    chk_cmd("decay_t3_lat", 1'b0, 2'd0, 2'd0);
    cyc();
    chk_cmd("decay_t3", 1'b1, 2'd3, 2'd1);
    repeat (8) cyc();
    tick(9);
    chk_cmd("decay_hold_t4", 1'b1, 2'd3, 2'd1);
    tick(9);
    chk_cmd("decay_hold_t5", 1'b1, 2'd3, 2'd1);
    cmd_if.cmd_ready = 1'b1;
    cyc();
    chk_cmd("decay_done", 1'b0, 2'd0, 2'd0);
    btn_salud = 1'b1;
    cyc();
    btn_salud = 1'b0;
    cyc();
    chk("view_salud", {6'd0, view_sel}, 8'd0);
    chk_cmd("view_salud_nocmd", 1'b0, 2'd0, 2'd0);
    btn_salud = 1'b1;
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
    btn_salud = 1'b0;
    chk_cmd("arb_lat", 1'b0, 2'd0, 2'd0);
    cyc();
    chk_cmd("arb_0", 1'b1, 2'd0, 2'd0);
    cyc();
    chk_cmd("arb_1", 1'b1, 2'd1, 2'd1);
    cyc();
    chk_cmd("arb_2", 1'b1, 2'd2, 2'd1);
    cyc();
    chk_cmd("arb_3", 1'b1, 2'd3, 2'd1);
    cyc();
    chk_cmd("arb_idle", 1'b0, 2'd0, 2'd0);
    btn_test = 1'b1;
    repeat (4) tick(2);
    chk("test_before", {7'd0, test_mode}, 8'd0);
    tick(0);
    chk("test_on", {7'd0, test_mode}, 8'd1);
    cyc();
    chk_cmd("test_clears_expiry", 1'b0, 2'd0, 2'd0);
    seen = 1'b0;
    repeat (200) begin
      tick_1s = 1'b1;
      cyc();
      seen = seen | cmd_if.cmd_valid;
    end
    tick_1s = 1'b0;
    cyc();
    chk("test_no_decay", {7'd0, seen | cmd_if.cmd_valid}, 8'd0);
    chk("test_no_retoggle", {7'd0, test_mode}, 8'd1);
    btn_salud = 1'b1;
    cyc();
    cyc();
    chk_cmd("force_min", 1'b1, 2'd0, 2'd2);
    btn_salud = 1'b0;
    cyc();
    chk_cmd("force_min_done", 1'b0, 2'd0, 2'd0);
    btn_salud = 1'b1;
    cyc();
    cyc();
    chk_cmd("force_max", 1'b1, 2'd0, 2'd3);
    btn_salud = 1'b0;
    cyc();
    cmd_if.cmd_ready = 1'b0;
    btn_salud = 1'b1;
    cyc();
    btn_salud = 1'b0;
    cyc();
    chk_cmd("out_pending", 1'b1, 2'd0, 2'd2);
    btn_salud = 1'b1;
    cyc();
    btn_salud = 1'b0;
    btn_test = 1'b0;
    cyc();
    btn_test = 1'b1;
    repeat (5) tick(2);
    chk("test_off", {7'd0, test_mode}, 8'd0);
    chk_cmd("out_held", 1'b1, 2'd0, 2'd2);
    cmd_if.cmd_ready = 1'b1;
    cyc();
    chk_cmd("pend_cleared", 1'b0, 2'd0, 2'd0);
    cyc();
    chk_cmd("pend_cleared2", 1'b0, 2'd0, 2'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
